// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, and device ACK check. Pins are driven only through active-high pull-low enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic [8:0]       r_shift;
    logic [3:0]       r_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_oe, r_data_oe, r_busy, r_ready, r_done, r_error;

    state_t           w_state_nxt;
    logic [8:0]       w_shift_nxt;
    logic [3:0]       w_n_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_oe_nxt, w_data_oe_nxt, w_done_nxt, w_error_nxt;
    logic             w_abort;
    logic             w_fe;
    logic             w_timeout;

    assign w_fe      = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    // Shared counter times the inhibit window, then the gap between device clock edges
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_n_nxt       = r_n;
        w_cnt_nxt     = r_cnt;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_abort       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    w_shift_nxt  = {~^tx_data, tx_data};
                    w_n_nxt      = 4'd0;
                    w_cnt_nxt    = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == INHIBIT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = S_RTS;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RTS: begin
                // First device edge puts data bit 0 on the line
                if (w_fe) begin
                    w_cnt_nxt     = '0;
                    w_data_oe_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[8:1]};
                    w_n_nxt       = 4'd1;
                    w_state_nxt   = S_SEND;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (w_fe) begin
                    w_cnt_nxt = '0;
                    if (r_n == 4'd9) begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = S_ACK;
                    end else begin
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[8:1]};
                        w_n_nxt       = r_n + 4'd1;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (w_fe) begin
                    w_cnt_nxt = '0;
                    if (!r_dat_s2) begin
                        w_state_nxt = S_WAIT_IDLE;
                    end else begin
                        w_error_nxt   = 1'b1;
                        w_clk_oe_nxt  = 1'b0;
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_error_nxt   = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_IDLE;
        end
    end

    // Synchronizers idle high to match released bus lines
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_shift    <= '0;
            r_n        <= '0;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_n        <= w_n_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_ready    <= (w_state_nxt == S_IDLE);
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign tx_ready    = r_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign tx_done     = r_done;
    assign tx_error    = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and samples the
// open-drain data line, compared against frame bits computed from the byte.
module tb_ps2_host_tx;

    localparam int unsigned INH = 8;
    localparam int unsigned TMO = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_error;

    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    int         n_done = 0;
    int         n_err  = 0;
    int         mon_run = 0;
    logic [1:0] mon_oe = 2'b00;
    logic       mon_ready_after = 1'b0;
    logic       mon_prev_pulse = 1'b0;

    // Open-drain wired-AND with pull-ups on both lines
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clock = ~clock;

    // Pulse monitor: counts done/error pulses, their width, line state and following tx_ready
    always @(negedge clock) begin
        if (mon_prev_pulse) mon_ready_after <= tx_ready;
        if (tx_done) n_done <= n_done + 1;
        if (tx_error) n_err <= n_err + 1;
        if (tx_done || tx_error) begin
            mon_oe  <= {ps2_clk_oe, ps2_data_oe};
            mon_run <= mon_prev_pulse ? mon_run + 1 : 1;
        end
        mon_prev_pulse <= tx_done | tx_error;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line levels a device should see at its 10 sampling points: data LSB first, odd parity, stop
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic start_frame(input logic [7:0] b);
        int cyc;
        check("ready_before", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("clk_oe_accept", 32'(ps2_clk_oe), 32'd1);
        check("busy_accept", 32'(busy), 32'd1);
        check("ready_accept", 32'(tx_ready), 32'd0);
        check("data_oe_inhibit", 32'(ps2_data_oe), 32'd0);
        cyc = 1;
        while (ps2_clk_oe === 1'b1 && cyc < 100) begin
            tick(1);
            if (ps2_clk_oe === 1'b1) cyc++;
        end
        check("inhibit_len", 32'(cyc), 32'(INH));
        check("start_bit", 32'(ps2_data_oe), 32'd1);
    endtask

    task automatic dev_edge(output logic seen);
        dev_clk = 1'b0;
        tick(40);
        seen = ps2_data_in;
        dev_clk = 1'b1;
        tick(40);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ack_ok, input bit poke_busy);
        logic [9:0] got;
        logic       seen;
        int d0, e0, cyc;
        d0 = n_done;
        e0 = n_err;
        start_frame(b);
        tick(10);
        for (int k = 1; k <= 10; k++) begin
            if (poke_busy && k == 4) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
                check("busy_send", 32'(busy), 32'd1);
                check("ready_send", 32'(tx_ready), 32'd0);
            end
            dev_edge(seen);
            got[k-1] = seen;
        end
        check("frame_bits", 32'(got), 32'(frame_bits(b)));
        if (ack_ok) dev_data = 1'b0;
        tick(5);
        dev_clk = 1'b0;
        tick(40);
        dev_clk = 1'b1;
        tick(5);
        dev_data = 1'b1;
        cyc = 0;
        while (n_done == d0 && n_err == e0 && cyc < 200) begin
            tick(1);
            cyc++;
        end
        tick(3);
        check("done_count", 32'(n_done - d0), ack_ok ? 32'd1 : 32'd0);
        check("error_count", 32'(n_err - e0), ack_ok ? 32'd0 : 32'd1);
        check("pulse_width", 32'(mon_run), 32'd1);
        check("pulse_oe", 32'(mon_oe), 32'd0);
        check("ready_after", 32'(mon_ready_after), 32'd1);
    endtask

    initial begin
        logic       seen;
        logic [7:0] rb;
        int         cyc, d0, e0;

        // Reset
        tick(3);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        reset = 1'b0;
        tick(5);

        // Directed commands with ACK
        send_frame(8'hED, 1'b1, 1'b0);
        send_frame(8'hF4, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);

        // Random bytes with ACK
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b1, 1'b0);
        end

        // Device withholds ACK
        send_frame(8'hFF, 1'b0, 1'b0);

        // Request while busy is ignored
        send_frame(8'hA3, 1'b1, 1'b1);

        // Device never clocks: timeout from RTS entry
        d0 = n_done;
        e0 = n_err;
        start_frame(8'($urandom_range(0, 255)));
        cyc = 0;
        while (tx_error !== 1'b1 && cyc < 400) begin
            tick(1);
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TMO));
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        tick(1);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_pulse_1cyc", 32'(tx_error), 32'd0);
        tick(3);
        check("timeout_err_count", 32'(n_err - e0), 32'd1);
        check("timeout_done_count", 32'(n_done - d0), 32'd0);

        // Reset mid-frame after device edge 4 (bit 3 of 0xF0 is 0, so data is pulled low)
        d0 = n_done;
        e0 = n_err;
        start_frame(8'hF0);
        tick(10);
        for (int k = 1; k <= 3; k++) dev_edge(seen);
        dev_clk = 1'b0;
        tick(40);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        dev_clk = 1'b1;
        tick(100);
        check("midrst_done_count", 32'(n_done - d0), 32'd0);
        check("midrst_err_count", 32'(n_err - e0), 32'd0);

        // Link still usable after the aborted frame
        send_frame(8'hF4, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
